// File: rtl/vip_uart_rx_monitor.sv
// vip_uart_rx_monitor: simulation-side UART receiver for the VIP. It samples the SoC
// transmit line, frames 8N1 (8E1 when VIP_UART_PARITY_EN is defined) LSB-first bytes
// and queues them in a small FIFO for the console printer and the output checker.
// Handshake: byte_o is valid while byte_valid_o is high; the head is popped on every
// rising clock edge where byte_valid_o && byte_ready_i. There is no backpressure on the
// serial side: a good byte arriving at a full FIFO with no pop that cycle is dropped.
module vip_uart_rx_monitor #(
    parameter int ClkDivWidth = 16,
    parameter int FifoDepth   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [ClkDivWidth-1:0]       clk_div_i,
    input  logic                         uart_rx_i,
    output logic [7:0]                   byte_o,
    output logic                         byte_valid_o,
    input  logic                         byte_ready_i,
    output logic                         frame_err_o,
    output logic                         parity_err_o,
    output logic                         overflow_o,
    output logic [$clog2(FifoDepth):0]   fill_o,
    output logic [2:0]                   dbg_state_o
);

    localparam int PtrW = $clog2(FifoDepth);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_sync;
    logic                   r_rx_prev;
    logic [ClkDivWidth-1:0] r_div;
    logic [ClkDivWidth-1:0] r_cnt;
    logic [7:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic                   r_par_bad;
    logic                   r_frame_err;
    logic                   r_overflow;
`ifdef VIP_UART_PARITY_EN
    logic                   r_parity_err;
`endif

    logic [7:0]             r_mem [FifoDepth];
    logic [PtrW-1:0]        r_wr_ptr;
    logic [PtrW-1:0]        r_rd_ptr;
    logic [PtrW:0]          r_count;

    logic                   w_rx;
    logic [ClkDivWidth-1:0] w_div;
    logic                   w_sample;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_wr;

    // Everything downstream sees the line two flops late; the counter holds the
    // number of cycles left until the next sample, so a sample fires when it hits zero.
    assign w_rx     = r_sync[1];
    assign w_div    = (clk_div_i < ClkDivWidth'(4)) ? ClkDivWidth'(4) : clk_div_i;
    assign w_sample = (r_cnt == '0);
    assign w_push   = (r_state == ST_STOP) && w_sample && w_rx && !r_par_bad;
    assign w_full   = (r_count == (PtrW+1)'(FifoDepth));
    assign w_pop    = (r_count != '0) && byte_ready_i;
    assign w_wr     = w_push && (!w_full || w_pop);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], uart_rx_i};
        end
    end

    // Frame FSM: start detect, mid-bit sampling, shift register and error pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_rx_prev   <= 1'b1;
            r_div       <= '0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_par_bad   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef VIP_UART_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_prev   <= w_rx;
            r_frame_err <= 1'b0;
`ifdef VIP_UART_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (r_rx_prev && !w_rx) begin
                        r_div   <= w_div;
                        r_cnt   <= (w_div >> 1) - 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_sample) begin
                        if (w_rx) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt     <= r_div - 1'b1;
                            r_bit_cnt <= '0;
                            r_par_bad <= 1'b0;
                            r_state   <= ST_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_cnt     <= r_div - 1'b1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef VIP_UART_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef VIP_UART_PARITY_EN
                ST_PARITY: begin
                    if (w_sample) begin
                        // Even parity: data bits plus parity bit must XOR to zero.
                        if (^{r_shift, w_rx}) begin
                            r_par_bad    <= 1'b1;
                            r_parity_err <= 1'b1;
                        end
                        r_cnt   <= r_div - 1'b1;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_sample) begin
                        if (!w_rx) begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (w_rx) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, the head is masked when empty.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers, occupancy and the overflow pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && w_full && !w_pop;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign byte_valid_o = (r_count != '0);
    assign byte_o       = byte_valid_o ? r_mem[r_rd_ptr] : 8'h00;
    assign fill_o       = r_count;
    assign frame_err_o  = r_frame_err;
    assign overflow_o   = r_overflow;
    assign dbg_state_o  = r_state;
`ifdef VIP_UART_PARITY_EN
    assign parity_err_o = r_parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
